rf_port_arbiter: RTL and testbench
==================================

RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, data width of the register file ports.
REQ-002 Parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 wr_req[1:0]  input  2  per-requester write request, held until granted.
REQ-006 wr_addr0, wr_addr1  input  ADDR_W each  write address of requester 0 and requester 1.
REQ-007 wr_data0, wr_data1  input  DATA_W each  write data of requester 0 and requester 1.
REQ-008 wr_gnt[1:0]  output  2  combinational one-hot write grant.
REQ-009 rd_req[1:0]  input  2  per-requester read request, held until granted.
REQ-010 rd_addr0, rd_addr1  input  ADDR_W each  read address of requester 0 and requester 1.
REQ-011 rd_gnt[1:0]  output  2  combinational one-hot read grant.
REQ-012 rd_valid[1:0]  output  2  registered one-hot read-data-valid, one cycle after rd_gnt.
REQ-013 rd_data  output  DATA_W  registered read data, qualified by rd_valid.
REQ-014 rf_wen  output  1  register file write enable.
REQ-015 rf_waddr  output  ADDR_W  register file write address.
REQ-016 rf_wdata  output  DATA_W  register file write data.
REQ-017 rf_raddr  output  ADDR_W  register file read address.
REQ-018 rf_rdata  input  DATA_W  combinational register file read data for rf_raddr.

Function
REQ-019 The block SHALL grant the write port to at most one requester per cycle; rf_wen = |wr_gnt.
REQ-020 The block SHALL grant the read port to at most one requester per cycle, independently of the write arbitration.
REQ-021 Each port SHALL use a 1-bit round-robin priority pointer: the requester named by the pointer wins when both request; a lone requester always wins.
REQ-022 A port's pointer SHALL update at the clock edge only when that port grants, and SHALL then point to the requester not granted.
REQ-023 rf_waddr/rf_wdata SHALL mirror the granted requester's address/data; with no write grant they SHALL be 0.
REQ-024 rf_raddr SHALL mirror the granted reader's address; with no read grant it SHALL be 0.
REQ-025 On the edge after a read grant to requester i, rd_valid[i] SHALL be 1 for exactly one cycle and rd_data SHALL hold the captured data.
REQ-026 Captured data SHALL be rf_rdata, except when a write is granted in the same cycle to the same address: captured data SHALL then be the granted write data (bypass).
REQ-027 When no read is granted, rd_valid SHALL be 2'b00 on the next cycle and rd_data SHALL hold its previous value.
REQ-028 Grant latency SHALL be 0 cycles when uncontended; a continuously held request SHALL be granted within 2 cycles (starvation bound).
REQ-029 A requester that drops its request before a grant SHALL lose no state and SHALL cause no pointer update.
REQ-030 Outputs wr_gnt, rd_gnt, rf_* SHALL be purely combinational from requests and pointers; rd_valid and rd_data SHALL be registers.

Reset
REQ-031 While reset is asserted, both pointers SHALL be 0 (requester 0 favoured), rd_valid SHALL be 2'b00, and rd_data SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL cancel any pending rd_valid asynchronously; grants still follow the requests combinationally with pointers at 0.

Verification
REQ-033 After reset, wr_req=2'b11 held 4 cycles -> wr_gnt sequence 01,10,01,10; rf_wen=1 in every cycle.
REQ-034 rd_req=2'b01, rd_addr0=5, rf_rdata=16'hBEEF -> rd_gnt=01 in the same cycle, rf_raddr=5; next cycle rd_valid=01, rd_data=16'hBEEF.
REQ-035 Same cycle: write grant requester 1 to addr 3 with data 16'h1234, read grant requester 0 to addr 3 with rf_rdata=16'h0000 -> next cycle rd_valid=01, rd_data=16'h1234.
REQ-036 Same cycle: write to addr 2, read of addr 4 -> rd_data=rf_rdata; no bypass.
REQ-037 rd_req=2'b10 granted, then reset pulsed before the next edge -> rd_valid=00, rd_data=0; afterwards rd_req=2'b11 -> requester 0 granted first.
REQ-038 wr_req=2'b00 and rd_req=2'b00 -> rf_wen=0, rf_waddr=0, rf_wdata=0, rf_raddr=0; pointers unchanged.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - round-robin arbitration of two requesters onto one register file write port and one read port
module rf_port_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        wr_req,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   output logic [1:0]        wr_gnt,
   input  logic [1:0]        rd_req,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [1:0]        rd_gnt,
   output logic [1:0]        rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rf_wen,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata
);

   // Each pointer names the requester favoured on the next contended cycle.
   logic wr_ptr;
   logic rd_ptr;
   logic bypass;

   always_comb begin
      wr_gnt   = wr_req;
      rd_gnt   = rd_req;
      rf_waddr = '0;
      rf_wdata = '0;
      rf_raddr = '0;
      if (wr_req == 2'b11) wr_gnt = wr_ptr ? 2'b10 : 2'b01;
      if (rd_req == 2'b11) rd_gnt = rd_ptr ? 2'b10 : 2'b01;
      if (wr_gnt[0]) begin
         rf_waddr = wr_addr0;
         rf_wdata = wr_data0;
      end else if (wr_gnt[1]) begin
         rf_waddr = wr_addr1;
         rf_wdata = wr_data1;
      end
      if (rd_gnt[0])      rf_raddr = rd_addr0;
      else if (rd_gnt[1]) rf_raddr = rd_addr1;
   end

   assign rf_wen = |wr_gnt;
   // A same-cycle write to the address being read supplies the read data.
   assign bypass = rf_wen && (rf_waddr == rf_raddr);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         rd_valid <= 2'b00;
         rd_data  <= '0;
      end else begin
         if (|wr_gnt) wr_ptr <= wr_gnt[0];
         if (|rd_gnt) begin
            rd_ptr  <= rd_gnt[0];
            rd_data <= bypass ? rf_wdata : rf_rdata;
         end
         rd_valid <= rd_gnt;
      end
   end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb/tb_rf_port_arbiter.sv - self-checking bench for rf_port_arbiter
module tb_rf_port_arbiter;
   localparam int DW = 16;
   localparam int AW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    wr_req = '0;
   logic [AW-1:0] wr_addr0 = '0, wr_addr1 = '0;
   logic [DW-1:0] wr_data0 = '0, wr_data1 = '0;
   logic [1:0]    rd_req = '0;
   logic [AW-1:0] rd_addr0 = '0, rd_addr1 = '0;
   logic [DW-1:0] rf_rdata = '0;
   logic [1:0]    wr_gnt, rd_gnt, rd_valid;
   logic [DW-1:0] rd_data, rf_wdata;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr, rf_raddr;

   rf_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
      .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Model state: favoured requester index per port, and the read pipeline stage.
   int            m_wfav = 0;
   int            m_rfav = 0;
   logic [1:0]    m_valid = '0;
   logic [DW-1:0] m_data = '0;

   function automatic int winner(input logic [1:0] req, input int fav);
      if (req == 2'b00) return -1;
      if (req == 2'b11) return fav;
      return req[1] ? 1 : 0;
   endfunction

   function automatic logic [1:0] onehot(input int w);
      if (w < 0) return 2'b00;
      return 2'b01 << w;
   endfunction

   always @(posedge clock or posedge reset) begin
      int ww, rw;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      if (reset) begin
         m_wfav  = 0;
         m_rfav  = 0;
         m_valid = 2'b00;
         m_data  = '0;
      end else begin
         ww = winner(wr_req, m_wfav);
         rw = winner(rd_req, m_rfav);
         wa = (ww == 1) ? wr_addr1 : wr_addr0;
         wd = (ww == 1) ? wr_data1 : wr_data0;
         ra = (rw == 1) ? rd_addr1 : rd_addr0;
         if (ww >= 0) m_wfav = 1 - ww;
         m_valid = onehot(rw);
         if (rw >= 0) begin
            m_rfav = 1 - rw;
            m_data = (ww >= 0 && wa == ra) ? wd : rf_rdata;
         end
      end
   end

   always @(negedge clock) begin
      int ww, rw;
      ww = winner(wr_req, m_wfav);
      rw = winner(rd_req, m_rfav);
      check("m_wr_gnt", 32'(wr_gnt), 32'(onehot(ww)));
      check("m_rd_gnt", 32'(rd_gnt), 32'(onehot(rw)));
      check("m_rf_wen", 32'(rf_wen), 32'(ww >= 0));
      check("m_rf_waddr", 32'(rf_waddr), ww < 0 ? 32'd0 : 32'(ww == 1 ? wr_addr1 : wr_addr0));
      check("m_rf_wdata", 32'(rf_wdata), ww < 0 ? 32'd0 : 32'(ww == 1 ? wr_data1 : wr_data0));
      check("m_rf_raddr", 32'(rf_raddr), rw < 0 ? 32'd0 : 32'(rw == 1 ? rd_addr1 : rd_addr0));
      check("m_rd_valid", 32'(rd_valid), 32'(m_valid));
      check("m_rd_data", 32'(rd_data), 32'(m_data));
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [1:0] seq [4];
      seq = '{2'b01, 2'b10, 2'b01, 2'b10};

      repeat (2) @(negedge clock);
      check("reset_rd_valid", 32'(rd_valid), 32'h0);
      check("reset_rd_data", 32'(rd_data), 32'h0);
      next_cycle();
      reset = 1'b0;

      // Contended writes alternate starting from requester 0.
      wr_req = 2'b11; wr_addr0 = 3'd1; wr_addr1 = 3'd6; wr_data0 = 16'hAAAA; wr_data1 = 16'h5555;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("rr_wr_gnt", 32'(wr_gnt), 32'(seq[i]));
         check("rr_rf_wen", 32'(rf_wen), 32'h1);
         next_cycle();
      end

      // One grant to requester 0, an idle cycle, then contention favours requester 1.
      wr_req = 2'b01;
      next_cycle();
      wr_req = 2'b00; rd_req = 2'b00;
      @(negedge clock);
      check("idle_rf_wen", 32'(rf_wen), 32'h0);
      check("idle_rf_waddr", 32'(rf_waddr), 32'h0);
      check("idle_rf_wdata", 32'(rf_wdata), 32'h0);
      check("idle_rf_raddr", 32'(rf_raddr), 32'h0);
      next_cycle();
      wr_req = 2'b11;
      @(negedge clock);
      check("idle_ptr_kept", 32'(wr_gnt), 32'h2);
      next_cycle();
      wr_req = 2'b00;

      // Plain read.
      rd_req = 2'b01; rd_addr0 = 3'd5; rf_rdata = 16'hBEEF;
      @(negedge clock);
      check("rd_gnt_same_cycle", 32'(rd_gnt), 32'h1);
      check("rd_raddr", 32'(rf_raddr), 32'h5);
      next_cycle();
      rd_req = 2'b00; rf_rdata = 16'h0;
      @(negedge clock);
      check("rd_valid_next", 32'(rd_valid), 32'h1);
      check("rd_data_next", 32'(rd_data), 32'hBEEF);

      // Bypass: same address written and read.
      wr_req = 2'b10; wr_addr1 = 3'd3; wr_data1 = 16'h1234;
      rd_req = 2'b01; rd_addr0 = 3'd3; rf_rdata = 16'h0000;
      next_cycle();
      wr_req = 2'b00; rd_req = 2'b00;
      @(negedge clock);
      check("bypass_valid", 32'(rd_valid), 32'h1);
      check("bypass_data", 32'(rd_data), 32'h1234);

      // Different addresses: no bypass.
      wr_req = 2'b01; wr_addr0 = 3'd2; wr_data0 = 16'h7777;
      rd_req = 2'b10; rd_addr1 = 3'd4; rf_rdata = 16'hCAFE;
      next_cycle();
      wr_req = 2'b00; rd_req = 2'b00;
      @(negedge clock);
      check("nobypass_valid", 32'(rd_valid), 32'h2);
      check("nobypass_data", 32'(rd_data), 32'hCAFE);
      check("hold_no_read", 32'(rd_valid), 32'h2);
      next_cycle();
      @(negedge clock);
      check("hold_valid_clear", 32'(rd_valid), 32'h0);
      check("hold_data", 32'(rd_data), 32'hCAFE);

      // Reset mid-operation cancels the pending read.
      rd_req = 2'b10; rd_addr1 = 3'd1; rf_rdata = 16'h1111;
      @(negedge clock);
      check("pre_reset_gnt", 32'(rd_gnt), 32'h2);
      next_cycle();
      rd_req = 2'b11; rf_rdata = 16'h2222;
      reset = 1'b1;
      #1;
      check("async_rd_valid", 32'(rd_valid), 32'h0);
      check("async_rd_data", 32'(rd_data), 32'h0);
      check("reset_rd_gnt", 32'(rd_gnt), 32'h1);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("post_reset_gnt0", 32'(rd_gnt), 32'h1);
      next_cycle();
      @(negedge clock);
      check("post_reset_valid", 32'(rd_valid), 32'h1);
      check("post_reset_data", 32'(rd_data), 32'h2222);
      check("post_reset_gnt1", 32'(rd_gnt), 32'h2);
      next_cycle();

      // Mixed traffic over a small address range to exercise bypass and starvation bounds.
      for (int i = 0; i < 40; i++) begin
         wr_req = 2'($urandom_range(0, 3)); rd_req = 2'($urandom_range(0, 3));
         wr_addr0 = 3'($urandom_range(0, 1)); wr_addr1 = 3'($urandom_range(0, 1));
         rd_addr0 = 3'($urandom_range(0, 1)); rd_addr1 = 3'($urandom_range(0, 1));
         wr_data0 = 16'($urandom); wr_data1 = 16'($urandom); rf_rdata = 16'($urandom);
         next_cycle();
      end
      wr_req = 2'b00; rd_req = 2'b00;
      @(negedge clock);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
